ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: the send path that pairs with the PS/2 receive decoder, used to issue keyboard commands such as LED set, reset and typematic rate. It accepts one byte from the core, inhibits the bus, issues a request-to-send, and shifts out data, odd parity and stop on device-generated clock edges. It then checks the device acknowledge and reports done or error. Bus pins are open-drain: the block only ever pulls lines low via output enables.

---
 rtl/ps2_host_tx.sv | 158 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module  : ps2_host_tx
// Brief   : PS/2 host-to-device byte transmitter (inhibit, request-to-send,
//           device-clocked shift of data/parity/stop, acknowledge check).
// Revision: 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 1200,
    parameter int TIMEOUT_CYCLES = 24000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_ready,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_INHIBIT = 3'd1;
    localparam logic [2:0] c_REQ     = 3'd2;
    localparam logic [2:0] c_SEND    = 3'd3;
    localparam logic [2:0] c_ACK     = 3'd4;
    localparam logic [2:0] c_RELEASE = 3'd5;

    localparam logic [15:0] c_INH_LAST = 16'(INHIBIT_CYCLES - 1);
    localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  c_LAST_BIT = 4'd9;

    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic [3:0]  r_bit_cnt;
    logic [9:0]  r_frame;
    logic        r_ack_ok;
    logic [1:0]  r_clk_sync;
    logic [1:0]  r_data_sync;
    logic        r_clk_prev;

    logic w_clk_s;
    logic w_data_s;
    logic w_clk_fall;
    logic w_clk_edge;

    assign w_clk_s    = r_clk_sync[1];
    assign w_data_s   = r_data_sync[1];
    assign w_clk_fall = r_clk_prev & ~w_clk_s;
    assign w_clk_edge = r_clk_prev ^ w_clk_s;

    // Synchronizers reset to the idle-high bus level so no edge is seen at reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_bit_cnt   <= '0;
            r_frame     <= '0;
            r_ack_ok    <= 1'b0;
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_prev  <= 1'b1;
            tx_ready    <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk};
            r_data_sync <= {r_data_sync[0], ps2_data};
            r_clk_prev  <= w_clk_s;
            done        <= 1'b0;
            error       <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (tx_start) begin
                        r_frame    <= {1'b1, ~^tx_data, tx_data};
                        r_cnt      <= '0;
                        r_bit_cnt  <= '0;
                        ps2_clk_oe <= 1'b1;
                        tx_ready   <= 1'b0;
                        r_state    <= c_INHIBIT;
                    end
                end
                c_INHIBIT: begin
                    if (r_cnt == c_INH_LAST) begin
                        r_cnt       <= '0;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b1;
                        r_state     <= c_REQ;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    // Every state waiting on the device shares one edge-cleared watchdog.
                    if (!w_clk_edge && r_cnt == c_TMO_LAST) begin
                        r_cnt       <= '0;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        error       <= 1'b1;
                        tx_ready    <= 1'b1;
                        r_state     <= c_IDLE;
                    end else begin
                        r_cnt <= w_clk_edge ? 16'd0 : r_cnt + 16'd1;
                        case (r_state)
                            c_REQ: begin
                                if (w_clk_fall) begin
                                    ps2_data_oe <= ~r_frame[0];
                                    r_frame     <= {1'b0, r_frame[9:1]};
                                    r_bit_cnt   <= 4'd1;
                                    r_state     <= c_SEND;
                                end
                            end
                            c_SEND: begin
                                if (w_clk_fall) begin
                                    ps2_data_oe <= ~r_frame[0];
                                    r_frame     <= {1'b0, r_frame[9:1]};
                                    r_bit_cnt   <= r_bit_cnt + 4'd1;
                                    if (r_bit_cnt == c_LAST_BIT) begin
                                        r_state <= c_ACK;
                                    end
                                end
                            end
                            c_ACK: begin
                                if (w_clk_fall) begin
                                    r_ack_ok <= ~w_data_s;
                                    r_state  <= c_RELEASE;
                                end
                            end
                            c_RELEASE: begin
                                if (w_clk_s && w_data_s) begin
                                    r_cnt    <= '0;
                                    done     <= r_ack_ok;
                                    error    <= ~r_ack_ok;
                                    tx_ready <= 1'b1;
                                    r_state  <= c_IDLE;
                                end
                            end
                            default: begin
                                r_cnt       <= '0;
                                ps2_clk_oe  <= 1'b0;
                                ps2_data_oe <= 1'b0;
                                tx_ready    <= 1'b1;
                                r_state     <= c_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_ps2_host_tx
// Brief   : Self-checking bench for ps2_host_tx with a behavioural PS/2 device.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_start = 1'b0;
    logic       tx_ready, done, error;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    wire        w_bus_clk  = ~(ps2_clk_oe | dev_clk_low);
    wire        w_bus_data = ~(ps2_data_oe | dev_data_low);

    int n_checks = 0;
    int n_errors = 0;
    int n_done = 0, n_err = 0, dbl_done = 0, dbl_err = 0;
    int inh_run = 0, last_inh = 0;
    logic prev_done = 0, prev_err = 0, prev_clk_oe = 0;

    ps2_host_tx #(.INHIBIT_CYCLES(16), .TIMEOUT_CYCLES(200)) dut (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_start(tx_start),
        .tx_ready(tx_ready), .done(done), .error(error),
        .ps2_clk(w_bus_clk), .ps2_data(w_bus_data),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected bus sequence: start, D0..D7, odd parity, stop.
    function automatic logic [10:0] exp_frame(input logic [7:0] d);
        logic par;
        par = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, d, 1'b0};
    endfunction

    always @(negedge clk) begin
        if (done) n_done++;
        if (error) n_err++;
        if (done && prev_done) dbl_done++;
        if (error && prev_err) dbl_err++;
        if (done || error) check("ready_with_pulse", tx_ready, 1);
        if (ps2_clk_oe) inh_run++;
        else if (prev_clk_oe) begin
            last_inh = inh_run;
            inh_run = 0;
            check("data_oe_at_inhibit_end", ps2_data_oe, 1);
        end
        prev_done = done;
        prev_err = error;
        prev_clk_oe = ps2_clk_oe;
    end

    task automatic send_start(input logic [7:0] d);
        int t = 0;
        while (!tx_ready && t < 2000) begin @(negedge clk); t++; end
        check("ready_before_start", tx_ready, 1);
        tx_data = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data = 8'($urandom);
        check("accept_ready_low", tx_ready, 0);
        check("accept_clk_oe", ps2_clk_oe, 1);
    endtask

    // Device side: samples the start bit when the host releases clock, then clocks 11 times.
    task automatic dev_xfer(input bit ack_low, input int abort_at, output logic [10:0] seen);
        int t = 0;
        int base;
        seen = '0;
        base = n_done + n_err;
        while (!(ps2_data_oe && !ps2_clk_oe) && t < 2000) begin @(negedge clk); t++; end
        if (t >= 2000) begin check("request_seen", 0, 1); return; end
        repeat (5) @(negedge clk);
        seen[0] = w_bus_data;
        for (int i = 1; i <= 11; i++) begin
            if (i == 11 && ack_low) dev_data_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b1;
            if (i == abort_at) return;
            repeat (HALF) @(negedge clk);
            if (i <= 10) seen[i] = w_bus_data;
            dev_clk_low = 1'b0;
        end
        repeat (2) @(negedge clk);
        dev_data_low = 1'b0;
        t = 0;
        while (n_done + n_err == base && t < 500) begin @(negedge clk); t++; end
        if (t >= 500) check("completion_seen", 0, 1);
    endtask

    task automatic full_xfer(input string tag, input logic [7:0] d, input bit ack_low);
        logic [10:0] seen;
        int d0, e0;
        d0 = n_done; e0 = n_err;
        send_start(d);
        dev_xfer(ack_low, 0, seen);
        repeat (3) @(negedge clk);
        check({tag, "_frame"}, 32'(seen), 32'(exp_frame(d)));
        check({tag, "_done"}, n_done - d0, ack_low ? 1 : 0);
        check({tag, "_error"}, n_err - e0, ack_low ? 0 : 1);
        check({tag, "_ready"}, tx_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [10:0] seen;
        int t, d0, e0;
        logic [7:0] rd;
        bit rack;

        repeat (3) @(negedge clk);
        check("rst_ready", tx_ready, 1);
        check("rst_oes", {ps2_clk_oe, ps2_data_oe}, 0);
        check("rst_pulses", {done, error}, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        full_xfer("aa", 8'hAA, 1);
        check("aa_inhibit_len", last_inh, 16);

        full_xfer("x01", 8'h01, 1);
        full_xfer("x00", 8'h00, 1);

        for (int k = 0; k < 6; k++) begin
            rd = 8'($urandom);
            rack = ($urandom_range(0, 3) != 0);
            full_xfer("rand", rd, rack);
            check("rand_inhibit_len", last_inh, 16);
        end

        // Device never clocks: the watchdog must end the request.
        e0 = n_err;
        send_start(8'h5A);
        t = 0;
        while (ps2_clk_oe && t < 100) begin @(negedge clk); t++; end
        t = 0;
        while (n_err == e0 && t < 1000) begin @(negedge clk); t++; end
        check("tmo_window", (t >= 200 && t <= 210), 1);
        check("tmo_oes", {ps2_clk_oe, ps2_data_oe}, 0);
        check("tmo_ready", tx_ready, 1);

        full_xfer("nack", 8'h3C, 0);

        // tx_start mid-frame must be ignored.
        d0 = n_done;
        send_start(8'hAA);
        fork
            dev_xfer(1, 0, seen);
            begin
                repeat (200) @(negedge clk);
                tx_data = 8'h55;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
            end
        join
        repeat (30) @(negedge clk);
        check("mid_frame", 32'(seen), 32'(exp_frame(8'hAA)));
        check("mid_done", n_done - d0, 1);
        check("mid_no_restart", {tx_ready, ps2_clk_oe}, 2'b10);

        // Asynchronous reset while D4 is on the bus.
        send_start(8'hAA);
        dev_xfer(1, 5, seen);
        repeat (4) @(negedge clk);
        check("pre_rst_d4", ps2_data_oe, 1);
        #3 reset_n = 1'b0;
        #1;
        check("async_rst_oes", {ps2_clk_oe, ps2_data_oe}, 0);
        check("async_rst_ready", tx_ready, 1);
        dev_clk_low = 1'b0;
        dev_data_low = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        full_xfer("ed", 8'hED, 1);

        check("done_single_cycle", dbl_done, 0);
        check("error_single_cycle", dbl_err, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
